// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in ck cycles.
// pwm_in is synchronised, edges are detected on the synchronised level, and
// one period/high-time pair is reported per completed rising-to-rising cycle.
// Handshake: valid is a 1-cycle pulse with no back-pressure; period/high_time
// are updated on the same cycle valid is high and hold until the next update.
// A cycle that cannot complete within 2^CNT_W-1 counts is abandoned with a
// 1-cycle timeout pulse instead; level tells stuck-high from stuck-low.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    // Synchroniser chain and edge-history flop; runs regardless of en.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q <= s;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; a count at MAX abandons the cycle unless LOW sees the closing rise.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rise) state_d = HIGH;
                HIGH: begin
                    if (cnt_q == MAX) state_d = IDLE;
                    else if (fall)    state_d = LOW;
                end
                LOW: begin
                    if (rise)              state_d = HIGH;
                    else if (cnt_q == MAX) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter updates, result capture and the valid/timeout pulses.
    always_comb begin
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (!en) begin
            cnt_d  = '0;
            hcnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = rise ? ONE : '0;
                    hcnt_d = rise ? ONE : '0;
                end
                HIGH: begin
                    // A fall at MAX would need cnt to wrap, so it times out too.
                    if (cnt_q == MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else if (fall) begin
                        cnt_d = cnt_q + ONE;
                    end else begin
                        cnt_d  = cnt_q + ONE;
                        hcnt_d = hcnt_q + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = ONE;
                        hcnt_d   = ONE;
                    end else if (cnt_q == MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                end
            endcase
        end
    end

    assign period      = period_q;
    assign high_time   = high_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign level       = s;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture (CNT_W=8 so timeouts are reachable quickly).
module tb_pwm_capture;

    localparam int W = 8;

    logic         ck;
    logic         rst_n;
    logic         en;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         level;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Statistics collected once per cycle by step().
    int cyc = 0;
    int nvalid, ntimeout, dbl_valid, both_hi;
    int p_last, h_last, last_vcyc, vgap, tcyc;
    bit prev_valid;

    pwm_capture #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .ck          (ck),
        .rst_n       (rst_n),
        .en          (en),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .timeout     (timeout),
        .level       (level),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic clear_stats();
        nvalid = 0; ntimeout = 0; dbl_valid = 0; both_hi = 0;
        p_last = -1; h_last = -1; last_vcyc = -1; vgap = -1; tcyc = -1;
        prev_valid = 1'b0;
    endtask

    // Advance one cycle and sample outputs 1ns after the edge.
    task automatic step();
        @(posedge ck);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            nvalid++;
            p_last = period;
            h_last = high_time;
            if (prev_valid) dbl_valid++;
            if (last_vcyc >= 0) vgap = cyc - last_vcyc;
            last_vcyc = cyc;
        end
        if (timeout === 1'b1) begin
            ntimeout++;
            tcyc = cyc;
        end
        if (valid === 1'b1 && timeout === 1'b1) both_hi++;
        prev_valid = (valid === 1'b1);
    endtask

    task automatic hold(input bit lvl, input int n);
        pwm_in = lvl;
        repeat (n) step();
    endtask

    // Return to IDLE with pwm low and a settled synchroniser, then re-enable.
    task automatic restart();
        en = 1'b0;
        pwm_in = 1'b0;
        repeat (6) step();
        en = 1'b1;
        clear_stats();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0;
        #21;
        checks++; if (period !== 8'd0)    begin errors++; $display("FAIL rst_period got %0d exp 0", period); end
        checks++; if (high_time !== 8'd0) begin errors++; $display("FAIL rst_high got %0d exp 0", high_time); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL rst_valid got %0b exp 0", valid); end
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout); end
        checks++; if (level !== 1'b0)     begin errors++; $display("FAIL rst_level got %0b exp 0", level); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        restart();
        repeat (5) begin
            hold(1'b1, 3);
            hold(1'b0, 7);
        end
        checks++; if (nvalid !== 4)    begin errors++; $display("FAIL t1_nvalid got %0d exp 4", nvalid); end
        checks++; if (p_last !== 10)   begin errors++; $display("FAIL t1_period got %0d exp 10", p_last); end
        checks++; if (h_last !== 3)    begin errors++; $display("FAIL t1_high got %0d exp 3", h_last); end
        checks++; if (dbl_valid !== 0) begin errors++; $display("FAIL t1_valid_width got %0d exp 0", dbl_valid); end
        checks++; if (vgap !== 10)     begin errors++; $display("FAIL t1_valid_gap got %0d exp 10", vgap); end
        checks++; if (ntimeout !== 0)  begin errors++; $display("FAIL t1_timeout got %0d exp 0", ntimeout); end
    endtask

    task automatic test_duty_sweep();
        int highs[5] = '{1, 2, 50, 98, 99};
        restart();
        foreach (highs[k]) begin
            repeat (2) begin
                hold(1'b1, highs[k]);
                hold(1'b0, 100 - highs[k]);
            end
            checks++; if (p_last !== 100)      begin errors++; $display("FAIL t2_period_h%0d got %0d exp 100", highs[k], p_last); end
            checks++; if (h_last !== highs[k]) begin errors++; $display("FAIL t2_high_h%0d got %0d exp %0d", highs[k], h_last, highs[k]); end
        end
        checks++; if (ntimeout !== 0) begin errors++; $display("FAIL t2_timeout got %0d exp 0", ntimeout); end
    endtask

    task automatic test_stuck_high();
        int set_cyc;
        restart();
        set_cyc = cyc;
        hold(1'b1, 300);
        checks++; if (ntimeout !== 1)          begin errors++; $display("FAIL t3_ntimeout got %0d exp 1", ntimeout); end
        checks++; if (tcyc - set_cyc !== 258)  begin errors++; $display("FAIL t3_timeout_latency got %0d exp 258", tcyc - set_cyc); end
        checks++; if (nvalid !== 0)            begin errors++; $display("FAIL t3_nvalid got %0d exp 0", nvalid); end
        checks++; if (level !== 1'b1)          begin errors++; $display("FAIL t3_level got %0b exp 1", level); end
        checks++; if (dbg_state !== 2'd0)      begin errors++; $display("FAIL t3_state got %0d exp 0", dbg_state); end
        checks++; if (period !== 8'd100)       begin errors++; $display("FAIL t3_period_held got %0d exp 100", period); end
        checks++; if (high_time !== 8'd99)     begin errors++; $display("FAIL t3_high_held got %0d exp 99", high_time); end
    endtask

    task automatic test_max_period();
        restart();
        repeat (2) begin
            hold(1'b1, 10);
            hold(1'b0, 245);
        end
        hold(1'b1, 10);
        checks++; if (nvalid !== 2)   begin errors++; $display("FAIL t4a_nvalid got %0d exp 2", nvalid); end
        checks++; if (p_last !== 255) begin errors++; $display("FAIL t4a_period got %0d exp 255", p_last); end
        checks++; if (h_last !== 10)  begin errors++; $display("FAIL t4a_high got %0d exp 10", h_last); end
        checks++; if (ntimeout !== 0) begin errors++; $display("FAIL t4a_timeout got %0d exp 0", ntimeout); end
        restart();
        hold(1'b1, 10);
        hold(1'b0, 246);
        hold(1'b1, 10);
        hold(1'b0, 20);
        checks++; if (nvalid !== 0)       begin errors++; $display("FAIL t4b_nvalid got %0d exp 0", nvalid); end
        checks++; if (ntimeout !== 1)     begin errors++; $display("FAIL t4b_timeout got %0d exp 1", ntimeout); end
        checks++; if (level !== 1'b0)     begin errors++; $display("FAIL t4b_level got %0b exp 0", level); end
        checks++; if (period !== 8'd255)  begin errors++; $display("FAIL t4b_period_held got %0d exp 255", period); end
        checks++; if (both_hi !== 0)      begin errors++; $display("FAIL t4_valid_and_timeout got %0d exp 0", both_hi); end
    endtask

    task automatic test_enable_drop();
        int bad_valid = 0;
        int bad_hold = 0;
        bit v52 = 1'b0;
        int h52 = -1;
        restart();
        for (int i = 0; i < 60; i++) begin
            pwm_in = (i < 30) ? ((i % 10) < 4) : ((i % 10) < 3);
            en = !(i >= 33 && i < 38);
            step();
            if (i >= 33 && i <= 51) begin
                if (valid !== 1'b0) bad_valid++;
                if (period !== 8'd10 || high_time !== 8'd4) bad_hold++;
            end
            if (i == 52) begin
                v52 = valid;
                h52 = high_time;
            end
        end
        checks++; if (bad_valid !== 0) begin errors++; $display("FAIL t5_valid_during_gap got %0d exp 0", bad_valid); end
        checks++; if (bad_hold !== 0)  begin errors++; $display("FAIL t5_outputs_held got %0d exp 0", bad_hold); end
        checks++; if (v52 !== 1'b1)    begin errors++; $display("FAIL t5_valid_after_restore got %0b exp 1", v52); end
        checks++; if (h52 !== 3)       begin errors++; $display("FAIL t5_high_after_restore got %0d exp 3", h52); end
    endtask

    task automatic test_async_reset();
        restart();
        hold(1'b1, 3); hold(1'b0, 7);
        hold(1'b1, 3); hold(1'b0, 4);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (period !== 8'd0)    begin errors++; $display("FAIL t6_period got %0d exp 0", period); end
        checks++; if (high_time !== 8'd0) begin errors++; $display("FAIL t6_high got %0d exp 0", high_time); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL t6_valid got %0b exp 0", valid); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL t6_state got %0d exp 0", dbg_state); end
        #13 rst_n = 1'b1;
        clear_stats();
        repeat (3) begin
            hold(1'b1, 3);
            hold(1'b0, 7);
        end
        checks++; if (nvalid !== 2)  begin errors++; $display("FAIL t6_nvalid got %0d exp 2", nvalid); end
        checks++; if (p_last !== 10) begin errors++; $display("FAIL t6_period_after got %0d exp 10", p_last); end
        checks++; if (h_last !== 3)  begin errors++; $display("FAIL t6_high_after got %0d exp 3", h_last); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic();
        test_duty_sweep();
        test_stuck_high();
        test_max_period();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
